// File: rtl/video_pkg.sv
// Shared definitions for the video test source: 720p timing defaults,
// pattern encoding and the colour-bar palette.
package video_pkg;

   localparam int H_ACTIVE_720 = 1280;
   localparam int H_FP_720     = 110;
   localparam int H_SYNC_720   = 40;
   localparam int H_BP_720     = 220;
   localparam int V_ACTIVE_720 = 720;
   localparam int V_FP_720     = 5;
   localparam int V_SYNC_720   = 5;
   localparam int V_BP_720     = 20;

   localparam int H_BITS = 11;
   localparam int V_BITS = 10;

   typedef logic [23:0] rgb_t;

   typedef enum logic [1:0] {
      PAT_SOLID    = 2'd0,
      PAT_BARS     = 2'd1,
      PAT_CHECKER  = 2'd2,
      PAT_GRADIENT = 2'd3
   } pattern_t;

   localparam rgb_t BAR_COLORS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   // Comparator chain against bar boundaries; avoids a divider on h.
   function automatic logic [2:0] bar_index(input logic [H_BITS-1:0] h, input int bar_w);
      bar_index = 3'd0;
      for (int k = 1; k < 8; k++)
         if (int'(h) >= k * bar_w) bar_index = 3'(k);
   endfunction

endpackage

// File: rtl/video_timing.sv
// Raster timing generator: h/v counters with registered position, valid,
// sync and frame-start outputs, all one clock behind the counter state.
module video_timing
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_720,
   parameter int H_FP     = H_FP_720,
   parameter int H_SYNC   = H_SYNC_720,
   parameter int H_BP     = H_BP_720,
   parameter int V_ACTIVE = V_ACTIVE_720,
   parameter int V_FP     = V_FP_720,
   parameter int V_SYNC   = V_SYNC_720,
   parameter int V_BP     = V_BP_720
) (
   input  logic              clk,
   input  logic              rst,
   output logic [H_BITS-1:0] h_pos,
   output logic [V_BITS-1:0] v_pos,
   output logic [H_BITS-1:0] h_count,
   output logic [V_BITS-1:0] v_count,
   output logic              data_valid,
   output logic              hsync,
   output logic              vsync,
   output logic              new_frame
);

   localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [H_BITS-1:0] HA_END   = H_BITS'(H_ACTIVE);
   localparam logic [V_BITS-1:0] VA_END   = V_BITS'(V_ACTIVE);
   localparam logic [H_BITS-1:0] HS_START = H_BITS'(H_ACTIVE + H_FP);
   localparam logic [H_BITS-1:0] HS_END   = H_BITS'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_BITS-1:0] VS_START = V_BITS'(V_ACTIVE + V_FP);
   localparam logic [V_BITS-1:0] VS_END   = V_BITS'(V_ACTIVE + V_FP + V_SYNC);

   logic [H_BITS-1:0] h;
   logic [V_BITS-1:0] v;

   assign h_pos = h;
   assign v_pos = v;

   // NOTE: non-blocking assignments let every output capture the pre-edge h/v.
   always_ff @(posedge clk) begin
      if (rst) begin
         h          <= '0;
         v          <= '0;
         h_count    <= '0;
         v_count    <= '0;
         data_valid <= 1'b0;
         hsync      <= 1'b0;
         vsync      <= 1'b0;
         new_frame  <= 1'b0;
      end else begin
         h_count    <= h;
         v_count    <= v;
         data_valid <= (h < HA_END) && (v < VA_END);
         hsync      <= (h >= HS_START) && (h < HS_END);
         vsync      <= (v >= VS_START) && (v < VS_END);
         new_frame  <= (h == '0) && (v == '0);
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

endmodule

// File: rtl/video_test_source.sv
// Test-pattern pixel source: raster timing plus per-frame pattern latch,
// registered pattern generation and a frame counter.
module video_test_source
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_720,
   parameter int H_FP     = H_FP_720,
   parameter int H_SYNC   = H_SYNC_720,
   parameter int H_BP     = H_BP_720,
   parameter int V_ACTIVE = V_ACTIVE_720,
   parameter int V_FP     = V_FP_720,
   parameter int V_SYNC   = V_SYNC_720,
   parameter int V_BP     = V_BP_720
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        pattern_sel,
   input  logic [23:0]       solid_color,
   output logic              data_valid,
   output logic [23:0]       pixel_data,
   output logic [H_BITS-1:0] h_count,
   output logic [V_BITS-1:0] v_count,
   output logic              hsync,
   output logic              vsync,
   output logic              new_frame,
   output logic [7:0]        frame_count
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [H_BITS-1:0] h_pos;
   logic [V_BITS-1:0] v_pos;
   logic              frame_start;
   logic              active;
   logic              seen_frame;
   pattern_t          pat_q;
   pattern_t          pat_cur;
   rgb_t              pix_d;

   video_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk        (clk),
      .rst        (rst),
      .h_pos      (h_pos),
      .v_pos      (v_pos),
      .h_count    (h_count),
      .v_count    (v_count),
      .data_valid (data_valid),
      .hsync      (hsync),
      .vsync      (vsync),
      .new_frame  (new_frame)
   );

   assign frame_start = (h_pos == '0) && (v_pos == '0);
   assign active      = (int'(h_pos) < H_ACTIVE) && (int'(v_pos) < V_ACTIVE);
   // The (0,0) pixel already uses the newly sampled pattern.
   assign pat_cur     = frame_start ? pattern_t'(pattern_sel) : pat_q;

   // NOTE: default first so every path assigns pix_d and no latch is inferred.
   always_comb begin
      pix_d = '0;
      if (active) begin
         case (pat_cur)
            PAT_SOLID:    pix_d = solid_color;
            PAT_BARS:     pix_d = BAR_COLORS[bar_index(h_pos, BAR_W)];
            PAT_CHECKER:  pix_d = (h_pos[4] ^ v_pos[4]) ? 24'hFFFFFF : 24'h000000;
            PAT_GRADIENT: pix_d = {h_pos[7:0], v_pos[7:0], h_pos[7:0] ^ v_pos[7:0]};
            default:      pix_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q       <= PAT_SOLID;
         seen_frame  <= 1'b0;
         frame_count <= '0;
         pixel_data  <= '0;
      end else begin
         pixel_data <= pix_d;
         pat_q      <= pat_cur;
         if (frame_start) begin
            if (seen_frame) frame_count <= frame_count + 1'b1;
            else            seen_frame  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_video_test_source.sv
// Directed bench: a full-720p instance checks line-level timing and bars,
// a reduced-raster instance checks frame-level behaviour within a short run.
module tb_video_test_source;

   // Reduced raster: 80 clocks/line, 48 lines/frame, 3840 clocks/frame.
   localparam int SH_ACTIVE = 64, SH_FP = 4, SH_SYNC = 4, SH_BP = 8;
   localparam int SV_ACTIVE = 40, SV_FP = 2, SV_SYNC = 3, SV_BP = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  hd_sel, sm_sel;
   logic [23:0] hd_solid, sm_solid;
   logic        hd_dv, hd_hs, hd_vs, hd_nf, sm_dv, sm_hs, sm_vs, sm_nf;
   logic [23:0] hd_pix, sm_pix;
   logic [10:0] hd_h, sm_h;
   logic [9:0]  hd_v, sm_v;
   logic [7:0]  hd_fc, sm_fc;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int cyc0     = 0;

   always #5 clk = ~clk;

   video_test_source u_hd (
      .clk(clk), .rst(rst), .pattern_sel(hd_sel), .solid_color(hd_solid),
      .data_valid(hd_dv), .pixel_data(hd_pix), .h_count(hd_h), .v_count(hd_v),
      .hsync(hd_hs), .vsync(hd_vs), .new_frame(hd_nf), .frame_count(hd_fc)
   );

   video_test_source #(
      .H_ACTIVE(SH_ACTIVE), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
      .V_ACTIVE(SV_ACTIVE), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
   ) u_sm (
      .clk(clk), .rst(rst), .pattern_sel(sm_sel), .solid_color(sm_solid),
      .data_valid(sm_dv), .pixel_data(sm_pix), .h_count(sm_h), .v_count(sm_v),
      .hsync(sm_hs), .vsync(sm_vs), .new_frame(sm_nf), .frame_count(sm_fc)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_sm(input int h, input int v);
      int n = 0;
      while (!(int'(sm_h) == h && int'(sm_v) == v) && n < 5000) begin
         step();
         n++;
      end
      checks++;
      if (n >= 5000) begin
         failures++;
         $display("FAIL wait_sm: position (%0d,%0d) never reached, at (%0d,%0d)", h, v, sm_h, sm_v);
      end
   endtask

   task automatic wait_sm_frame();
      int n = 0;
      step();
      while (sm_nf !== 1'b1 && n < 5000) begin
         step();
         n++;
      end
      checks++;
      if (n >= 5000) begin
         failures++;
         $display("FAIL wait_sm_frame: new_frame never seen");
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      hd_sel   = 2'd1;
      hd_solid = 24'h000000;
      sm_sel   = 2'd0;
      sm_solid = 24'h123456;
      repeat (5) step();
      checks++;
      if ((|{hd_dv, hd_pix, hd_h, hd_v, hd_hs, hd_vs, hd_nf, hd_fc}) !== 1'b0) begin
         failures++;
         $display("FAIL reset_hd_outputs: got %h required all zero", {hd_dv, hd_pix, hd_h, hd_v, hd_hs, hd_vs, hd_nf, hd_fc});
      end
      checks++;
      if ((|{sm_dv, sm_pix, sm_h, sm_v, sm_hs, sm_vs, sm_nf, sm_fc}) !== 1'b0) begin
         failures++;
         $display("FAIL reset_sm_outputs: got %h required all zero", {sm_dv, sm_pix, sm_h, sm_v, sm_hs, sm_vs, sm_nf, sm_fc});
      end
      rst = 1'b0;
      step();
      cyc0 = cyc;
      checks++;
      if ({hd_h, hd_v, hd_dv, hd_nf, hd_fc, hd_pix} !== {11'd0, 10'd0, 1'b1, 1'b1, 8'd0, 24'hFFFFFF}) begin
         failures++;
         $display("FAIL first_cycle_hd: got h=%0d v=%0d dv=%b nf=%b fc=%0d pix=%h required 0 0 1 1 0 ffffff",
                  hd_h, hd_v, hd_dv, hd_nf, hd_fc, hd_pix);
      end
      checks++;
      if ({sm_h, sm_v, sm_dv, sm_nf, sm_fc, sm_pix} !== {11'd0, 10'd0, 1'b1, 1'b1, 8'd0, 24'h123456}) begin
         failures++;
         $display("FAIL first_cycle_sm: got h=%0d v=%0d dv=%b nf=%b fc=%0d pix=%h required 0 0 1 1 0 123456",
                  sm_h, sm_v, sm_dv, sm_nf, sm_fc, sm_pix);
      end
   endtask

   // Full 720p line 0 with colour bars, then the wrap into line 1.
   task automatic test_hd_line();
      int hs_cnt = 0, hs_first = -1, hs_last = -1;
      for (int i = 1; i <= 1650; i++) begin
         logic [23:0] exp_pix;
         logic        exp_dv;
         bit          probe;
         step();
         if (hd_hs === 1'b1) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(hd_h);
            hs_last = int'(hd_h);
         end
         probe = 1'b1;
         exp_dv = 1'b1;
         case (i)
            159:     exp_pix = 24'hFFFFFF;
            160:     exp_pix = 24'hFFFF00;
            480:     exp_pix = 24'h00FF00;
            800:     exp_pix = 24'hFF0000;
            1279:    exp_pix = 24'h000000;
            1280:    begin exp_pix = 24'h000000; exp_dv = 1'b0; end
            default: begin exp_pix = 24'h0; probe = 1'b0; end
         endcase
         if (probe) begin
            checks++;
            if (int'(hd_h) != i || hd_dv !== exp_dv || hd_pix !== exp_pix) begin
               failures++;
               $display("FAIL bars_h%0d: got h=%0d dv=%b pix=%h required h=%0d dv=%b pix=%h",
                        i, hd_h, hd_dv, hd_pix, i, exp_dv, exp_pix);
            end
         end
      end
      checks++;
      if (hd_h !== 11'd0 || hd_v !== 10'd1) begin
         failures++;
         $display("FAIL line_wrap: got h=%0d v=%0d required h=0 v=1", hd_h, hd_v);
      end
      checks++;
      if (hs_cnt != 40 || hs_first != 1390 || hs_last != 1429) begin
         failures++;
         $display("FAIL hsync_line: got count=%0d first=%0d last=%0d required 40 1390 1429",
                  hs_cnt, hs_first, hs_last);
      end
   endtask

   // Frame period, frame_count and one full-frame census on the reduced raster.
   task automatic test_frame_scan();
      int dv_cnt = 0, hs_cnt = 0, vs_cnt = 0, bad_blank = 0, bad_solid = 0;
      int hs_min = 9999, hs_max = -1, vs_min = 9999, vs_max = -1;
      wait_sm_frame();
      checks++;
      if (cyc - cyc0 != 3840 || sm_fc !== 8'd1 || sm_h !== 11'd0 || sm_v !== 10'd0) begin
         failures++;
         $display("FAIL second_frame: got delta=%0d fc=%0d h=%0d v=%0d required 3840 1 0 0",
                  cyc - cyc0, sm_fc, sm_h, sm_v);
      end
      for (int i = 0; i < 3840; i++) begin
         if (sm_dv === 1'b1) begin
            dv_cnt++;
            if (sm_pix !== 24'h123456) bad_solid++;
         end else if (sm_pix !== 24'h0) begin
            bad_blank++;
         end
         if (sm_hs === 1'b1) begin
            hs_cnt++;
            if (int'(sm_h) < hs_min) hs_min = int'(sm_h);
            if (int'(sm_h) > hs_max) hs_max = int'(sm_h);
         end
         if (sm_vs === 1'b1) begin
            vs_cnt++;
            if (int'(sm_v) < vs_min) vs_min = int'(sm_v);
            if (int'(sm_v) > vs_max) vs_max = int'(sm_v);
         end
         step();
      end
      checks++;
      if (dv_cnt != 2560) begin
         failures++;
         $display("FAIL data_valid_count: got %0d required 2560", dv_cnt);
      end
      checks++;
      if (hs_cnt != 192 || hs_min != 68 || hs_max != 71) begin
         failures++;
         $display("FAIL hsync_frame: got count=%0d h=%0d..%0d required 192 68..71", hs_cnt, hs_min, hs_max);
      end
      checks++;
      if (vs_cnt != 240 || vs_min != 42 || vs_max != 44) begin
         failures++;
         $display("FAIL vsync_frame: got count=%0d v=%0d..%0d required 240 42..44", vs_cnt, vs_min, vs_max);
      end
      checks++;
      if (bad_blank != 0 || bad_solid != 0) begin
         failures++;
         $display("FAIL solid_pixels: got blank_errs=%0d solid_errs=%0d required 0 0", bad_blank, bad_solid);
      end
      checks++;
      if (sm_nf !== 1'b1 || sm_fc !== 8'd2) begin
         failures++;
         $display("FAIL third_frame: got nf=%b fc=%0d required 1 2", sm_nf, sm_fc);
      end
   endtask

   // Switching pattern mid-frame must not tear the current frame.
   task automatic test_pattern_switch();
      int bad = 0, n = 0;
      wait_sm(0, 10);
      sm_sel = 2'd1;
      step();
      while (sm_nf !== 1'b1 && n < 5000) begin
         if (sm_dv === 1'b1 && sm_pix !== 24'h123456) bad++;
         step();
         n++;
      end
      checks++;
      if (bad != 0 || n >= 5000) begin
         failures++;
         $display("FAIL no_tearing: got %0d changed pixels (timeout=%0d) required 0", bad, n >= 5000);
      end
      checks++;
      if (sm_fc !== 8'd3 || sm_pix !== 24'hFFFFFF) begin
         failures++;
         $display("FAIL bars_frame_start: got fc=%0d pix=%h required 3 ffffff", sm_fc, sm_pix);
      end
      for (int i = 1; i <= 64; i++) begin
         logic [23:0] exp_pix;
         bit          probe;
         step();
         probe = 1'b1;
         case (i)
            7:       exp_pix = 24'hFFFFFF;
            8:       exp_pix = 24'hFFFF00;
            16:      exp_pix = 24'h00FFFF;
            63:      exp_pix = 24'h000000;
            64:      exp_pix = 24'h000000;
            default: begin exp_pix = 24'h0; probe = 1'b0; end
         endcase
         if (probe) begin
            checks++;
            if (int'(sm_h) != i || sm_dv !== (i < 64) || sm_pix !== exp_pix) begin
               failures++;
               $display("FAIL sm_bars_h%0d: got h=%0d dv=%b pix=%h required pix=%h", i, sm_h, sm_dv, sm_pix, exp_pix);
            end
         end
      end
   endtask

   task automatic test_checker();
      sm_sel = 2'd2;
      wait_sm(8, 1);
      checks++;
      if (sm_pix !== 24'hFFFF00) begin
         failures++;
         $display("FAIL bars_hold: got %h required ffff00", sm_pix);
      end
      wait_sm(15, 0);
      checks++;
      if (sm_pix !== 24'h000000) begin
         failures++;
         $display("FAIL checker_15_0: got %h required 000000", sm_pix);
      end
      wait_sm(16, 0);
      checks++;
      if (sm_pix !== 24'hFFFFFF) begin
         failures++;
         $display("FAIL checker_16_0: got %h required ffffff", sm_pix);
      end
      wait_sm(0, 16);
      checks++;
      if (sm_pix !== 24'hFFFFFF) begin
         failures++;
         $display("FAIL checker_0_16: got %h required ffffff", sm_pix);
      end
      wait_sm(16, 16);
      checks++;
      if (sm_pix !== 24'h000000) begin
         failures++;
         $display("FAIL checker_16_16: got %h required 000000", sm_pix);
      end
   endtask

   task automatic test_gradient();
      sm_sel = 2'd3;
      wait_sm_frame();
      wait_sm(5, 3);
      checks++;
      if (sm_pix !== 24'h050306) begin
         failures++;
         $display("FAIL gradient_5_3: got %h required 050306", sm_pix);
      end
      wait_sm(43, 28);
      checks++;
      if (sm_pix !== 24'h2B1C37) begin
         failures++;
         $display("FAIL gradient_43_28: got %h required 2b1c37", sm_pix);
      end
      wait_sm(63, 39);
      checks++;
      if (sm_pix !== 24'h3F2718) begin
         failures++;
         $display("FAIL gradient_63_39: got %h required 3f2718", sm_pix);
      end
   endtask

   task automatic test_mid_reset();
      wait_sm_frame();
      wait_sm(50, 30);
      rst = 1'b1;
      step();
      checks++;
      if ((|{sm_dv, sm_pix, sm_h, sm_v, sm_hs, sm_vs, sm_nf, sm_fc, hd_dv, hd_pix, hd_h, hd_v, hd_nf, hd_fc}) !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_zero: got sm=%h hd=%h required all zero",
                  {sm_dv, sm_pix, sm_h, sm_v, sm_hs, sm_vs, sm_nf, sm_fc}, {hd_dv, hd_pix, hd_h, hd_v, hd_nf, hd_fc});
      end
      sm_sel   = 2'd0;
      sm_solid = 24'hABCDEF;
      rst      = 1'b0;
      step();
      checks++;
      if ({sm_h, sm_v, sm_dv, sm_nf, sm_fc, sm_pix} !== {11'd0, 10'd0, 1'b1, 1'b1, 8'd0, 24'hABCDEF}) begin
         failures++;
         $display("FAIL restart_sm: got h=%0d v=%0d dv=%b nf=%b fc=%0d pix=%h required 0 0 1 1 0 abcdef",
                  sm_h, sm_v, sm_dv, sm_nf, sm_fc, sm_pix);
      end
      checks++;
      if ({hd_h, hd_v, hd_nf, hd_fc, hd_pix} !== {11'd0, 10'd0, 1'b1, 8'd0, 24'hFFFFFF}) begin
         failures++;
         $display("FAIL restart_hd: got h=%0d v=%0d nf=%b fc=%0d pix=%h required 0 0 1 0 ffffff",
                  hd_h, hd_v, hd_nf, hd_fc, hd_pix);
      end
      step();
      checks++;
      if (sm_h !== 11'd1 || sm_nf !== 1'b0) begin
         failures++;
         $display("FAIL restart_count: got h=%0d nf=%b required 1 0", sm_h, sm_nf);
      end
   endtask

   initial begin
      test_reset();
      test_hd_line();
      test_frame_scan();
      test_pattern_switch();
      test_checker();
      test_gradient();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
